// File: rtl/fetch_rx_pkg.sv
// Shared types and constants for the instruction-fetch receive path.
package fetch_rx_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_beat_t;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_rx_if.sv
// IF-stage link: registered fetch stream forward, stall and redirect back.
interface fetch_rx_if;

  logic        is_valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        is_stall;
  logic        is_flush;
  logic [31:0] branch_target;

  modport master (output is_valid, pc, instr, input is_stall, is_flush, branch_target);
  modport slave  (input is_valid, pc, instr, output is_stall, is_flush, branch_target);

endinterface

// File: rtl/fetch_fifo_s.sv
// First-word-fall-through queue of fetch beats; clear empties it in one edge.
module fetch_fifo_s
  import fetch_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  fetch_beat_t din,
  output fetch_beat_t dout,
  output logic        empty,
  output logic [CW-1:0] count
);

  fetch_beat_t     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; empty masks stale entries at the output.
  always_ff @(posedge clk) begin
    if (reset && !clear && push) mem[wr_ptr] <= din;
  end

  overflow_a: assert property (@(posedge clk) disable iff (!reset) !(push && full && !clear));

endmodule

// File: rtl/fetch_rx_s.sv
// Fetch receive stage: beat queue, IF backpressure and EX redirect/drop control.
// Optional PC-continuity filter enabled by defining FETCH_RX_PC_CHECK_EN.
module fetch_rx_s
  import fetch_rx_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int DROP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  fetch_rx_if.slave   fi,
  input  logic        redirect_req,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [7:0]  pc_err_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = (DROP_CYCLES < 1) ? 1 : $clog2(DROP_CYCLES + 1);

  logic          stall_d1;
  logic [DW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          new_beat;
  logic          accept_raw;
  logic          accept;
  logic          pop;
  logic          empty;
  fetch_beat_t   head;
  fetch_beat_t   din;

  // A beat is new only if IF was not held at the edge that produced it.
  assign new_beat   = fi.is_valid && !stall_d1;
  assign accept_raw = new_beat && (drop_cnt == '0) && !redirect_req;
  assign pop        = out_valid && out_ready && !redirect_req;
  assign din        = '{pc: fi.pc, instr: fi.instr};

`ifdef FETCH_RX_PC_CHECK_EN
  logic [31:0] expected_pc;
  logic        seeded;
  logic        pc_ok;

  assign pc_ok  = !seeded || (fi.pc == expected_pc);
  assign accept = accept_raw && pc_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      expected_pc <= RESET_PC;
      seeded      <= 1'b0;
      pc_err_cnt  <= '0;
    end else begin
      if (redirect_req) begin
        expected_pc <= redirect_pc;
        seeded      <= 1'b1;
      end else if (accept) begin
        expected_pc <= fi.pc + PC_STEP;
        seeded      <= 1'b1;
      end
      if (accept_raw && !pc_ok && pc_err_cnt != 8'hFF) pc_err_cnt <= pc_err_cnt + 8'd1;
    end
  end
`else
  assign accept     = accept_raw;
  assign pc_err_cnt = '0;
`endif

  always_comb begin
    count_next = count;
    if (redirect_req) count_next = '0;
    else              count_next = count + CW'(accept) - CW'(pop);
  end

  // Stall one entry early: IF has one more beat in flight when it sees is_stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fi.is_stall      <= 1'b0;
      fi.is_flush      <= 1'b0;
      fi.branch_target <= RESET_PC;
      drop_cnt         <= '0;
      stall_d1         <= 1'b0;
    end else begin
      stall_d1    <= fi.is_stall;
      fi.is_flush <= redirect_req;
      fi.is_stall <= !redirect_req && (count_next >= CW'(DEPTH - 1));
      if (redirect_req) begin
        fi.branch_target <= redirect_pc;
        drop_cnt         <= DW'(DROP_CYCLES);
      end else if (new_beat && drop_cnt != '0) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo_s #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .clear (redirect_req),
    .din   (din),
    .dout  (head),
    .empty (empty),
    .count (count)
  );

  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_rx_s.sv
// Bench for fetch_rx_s: queue-based reference model plus directed fetch/redirect vectors.
// Extra PC-continuity vectors run when FETCH_RX_PC_CHECK_EN is defined.
module tb_fetch_rx_s;
  import fetch_rx_pkg::*;

  localparam int DEPTH = 4;
  localparam int DROP  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_req;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [7:0]  pc_err_cnt;

  fetch_rx_if fi ();

  fetch_rx_s #(.DEPTH(DEPTH), .DROP_CYCLES(DROP)) dut (
    .clk          (clk),
    .reset        (reset),
    .fi           (fi),
    .redirect_req (redirect_req),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .pc_err_cnt   (pc_err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] p);
    return ~p ^ 32'h1357_0000;
  endfunction

  // Reference model: state as seen after each rising edge.
  fetch_beat_t mq[$];
  int          m_drop;
  bit          m_stall, m_stall_prev, m_flush, m_live;
  logic [31:0] m_target;
  int          m_err;
  logic [31:0] m_exp;
  bit          m_seeded;

  initial begin
    bit nb, ok, do_pop;
    m_live = 0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        mq.delete();
        m_drop = 0; m_stall = 0; m_stall_prev = 0; m_flush = 0;
        m_target = 32'h0; m_err = 0; m_exp = 32'h0; m_seeded = 0;
        m_live = 1;
      end else begin
        nb = fi.is_valid && !m_stall_prev;
        m_stall_prev = m_stall;
        if (redirect_req) begin
          mq.delete();
          m_flush = 1; m_target = redirect_pc; m_drop = DROP; m_stall = 0;
          m_exp = redirect_pc; m_seeded = 1;
        end else begin
          m_flush = 0;
          do_pop = (mq.size() > 0) && out_ready;
          ok = nb && (m_drop == 0);
          if (nb && m_drop > 0) m_drop--;
`ifdef FETCH_RX_PC_CHECK_EN
          if (ok && m_seeded && fi.pc != m_exp) begin
            ok = 0;
            if (m_err < 255) m_err++;
          end
          if (ok) begin
            m_exp = fi.pc + 32'd4;
            m_seeded = 1;
          end
`endif
          if (ok) begin
            total++;
            if (mq.size() == DEPTH) begin
              bad++;
              $display("FAIL overflow got=push_on_full want=no_push t=%0t", $time);
            end
          end
          if (do_pop) void'(mq.pop_front());
          if (ok) mq.push_back('{pc: fi.pc, instr: fi.instr});
          m_stall = mq.size() >= DEPTH - 1;
        end
      end
    end
  end

  // Compare process: every negative edge once the model has seen reset.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("out_pc", out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
        chk("out_instr", out_instr, (mq.size() > 0) ? mq[0].instr : 32'h0);
        chk("is_stall", 32'(fi.is_stall), 32'(m_stall));
        chk("is_flush", 32'(fi.is_flush), 32'(m_flush));
        if (m_flush) chk("branch_target", fi.branch_target, m_target);
        chk("pc_err_cnt", 32'(pc_err_cnt), 32'(m_err));
      end
    end
  end

  logic [31:0] if_pc;

  // One cycle of a registered IF stage that holds its beat while stalled.
  task automatic feed(input logic rdy);
    logic s;
    s = fi.is_stall;
    fi.is_valid = 1'b1; fi.pc = if_pc; fi.instr = mk_instr(if_pc);
    out_ready = rdy; redirect_req = 1'b0;
    @(negedge clk);
    if (!s) if_pc = if_pc + 32'd4;
  endtask

  task automatic step(input logic v, input logic [31:0] p, input logic rdy,
                      input logic rq, input logic [31:0] rpc);
    fi.is_valid = v; fi.pc = p; fi.instr = mk_instr(p);
    out_ready = rdy; redirect_req = rq; redirect_pc = rpc;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset = 1'b0; fi.is_valid = 1'b0; redirect_req = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] t1_exp [3];
    t1_exp = '{32'h4, 32'h8, 32'hC};
    reset = 1'b0; fi.is_valid = 1'b1; fi.pc = 32'h4; fi.instr = mk_instr(32'h4);
    out_ready = 1'b0; redirect_req = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_is_stall", 32'(fi.is_stall), 32'h0);
    chk("rst_is_flush", 32'(fi.is_flush), 32'h0);
    chk("rst_target", fi.branch_target, 32'h0);

    // Basic stream with decode always ready: one-cycle accept-to-head latency.
    reset = 1'b1; if_pc = 32'h4;
    for (int k = 0; k < 3; k++) begin
      feed(1'b1);
      chk("t1_head", out_pc, t1_exp[k]);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Decode blocked: fill to DEPTH with the held beat not pushed twice.
    repeat (8) feed(1'b0);
    chk("t2_stall", 32'(fi.is_stall), 32'h1);
    chk("t2_head", out_pc, 32'h10);

    // Release: stall drops after two pops, stream resumes in order.
    repeat (2) feed(1'b1);
    chk("t3_stall_fall", 32'(fi.is_stall), 32'h0);
    chk("t3_head", out_pc, 32'h18);
    repeat (6) feed(1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Redirect with three queued beats.
    reset_pulse();
    if_pc = 32'h40;
    repeat (3) feed(1'b0);
    chk("t4_pre_stall", 32'(fi.is_stall), 32'h1);
    step(1'b1, 32'h4C, 1'b1, 1'b1, 32'h100);
    chk("t4_flushed", 32'(out_valid), 32'h0);
    chk("t4_flush", 32'(fi.is_flush), 32'h1);
    chk("t4_target", fi.branch_target, 32'h100);
    chk("t4_stall_clr", 32'(fi.is_stall), 32'h0);
    step(1'b1, 32'h4C, 1'b1, 1'b0, 32'h0);
    chk("t4_flush_1cyc", 32'(fi.is_flush), 32'h0);
    step(1'b1, 32'h50, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h54, 1'b1, 1'b0, 32'h0);
    chk("t4_dropped", 32'(out_valid), 32'h0);
    step(1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
    chk("t4_target_beat", out_pc, 32'h100);

    // Redirect coincident with ready and an incoming beat.
    step(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h108, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h10C, 1'b1, 1'b1, 32'h200);
    chk("t5_cleared", 32'(out_valid), 32'h0);
    chk("t5_target", fi.branch_target, 32'h200);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t5_empty", 32'(out_valid), 32'h0);
    step(1'b1, 32'h500, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h504, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("t5_target_beat", out_pc, 32'h200);

    // Back-to-back redirects: two pulses, last target wins.
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
    chk("t6_target0", fi.branch_target, 32'h300);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h340);
    chk("t6_flush2", 32'(fi.is_flush), 32'h1);
    chk("t6_target1", fi.branch_target, 32'h340);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t6_flush_end", 32'(fi.is_flush), 32'h0);
    step(1'b1, 32'h600, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h604, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h340, 1'b1, 1'b0, 32'h0);
    chk("t6_target_beat", out_pc, 32'h340);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

`ifdef FETCH_RX_PC_CHECK_EN
    // PC continuity: out-of-sequence beat is discarded and counted.
    reset_pulse();
    step(1'b1, 32'h4, 1'b1, 1'b0, 32'h0);
    chk("pc_head4", out_pc, 32'h4);
    step(1'b1, 32'h8, 1'b1, 1'b0, 32'h0);
    chk("pc_head8", out_pc, 32'h8);
    step(1'b1, 32'h20, 1'b1, 1'b0, 32'h0);
    chk("pc_discard", 32'(out_valid), 32'h0);
    chk("pc_err", 32'(pc_err_cnt), 32'h1);
    step(1'b1, 32'hC, 1'b1, 1'b0, 32'h0);
    chk("pc_headC", out_pc, 32'hC);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_rx_s.md
Name: fetch_rx_s

Overview:
- Receiving end of the instruction-fetch interface.
- Consumes the IF stage's registered stream (is_valid, pc, instr) and buffers beats in a small FWFT queue for decode.
- Generates the IF-facing is_stall backpressure and the is_flush/branch_target redirect.
- Sits between the IF stage and the ID stage; the redirect request comes from EX.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- DROP_CYCLES, 2, fetch beats discarded after an is_flush pulse (covers ROM plus IF register latency).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- is_valid  input  1  IF beat valid.
- pc  input  32  IF beat PC.
- instr  input  32  IF beat instruction.
- is_stall  output  1  registered; holds the IF stage.
- is_flush  output  1  registered one-cycle redirect pulse to IF.
- branch_target  output  32  registered redirect PC, valid while is_flush=1.
- redirect_req  input  1  EX requests a redirect.
- redirect_pc  input  32  redirect destination.
- out_valid  output  1  queue head valid.
- out_ready  input  1  decode accepts the head.
- out_pc  output  32  head PC.
- out_instr  output  32  head instruction.
- pc_err_cnt  output  8  PC-continuity discard count (feature only; tied 0 otherwise).

Behaviour:
- Reset (reset==0 at an edge):
  - Queue empty; count=0; is_stall=0; is_flush=0; branch_target=0; drop_cnt=0; stall_d1=0; pc_err_cnt=0.
  - out_valid=0; out_pc=0; out_instr=0 whenever the queue is empty.
  - Reset wins over every other event.
- stall_d1 is a flop holding the previous is_stall value. While IF is stalled it re-presents the same beat, so only beats produced by a non-stalled edge are new.
- Accept: accept = is_valid && !stall_d1 && drop_cnt==0 && !redirect_req.
  - An accepted beat with a full queue is a design error; a bench assertion must fire.
- Pop: pop = out_valid && out_ready && !redirect_req.
- Push and pop in the same cycle:
  - Both apply and count is unchanged.
  - When the queue is empty, the beat is written and becomes visible next cycle. There is no bypass; latency from accept to out_valid is 1 cycle.
- Stall: is_stall_next = (count_next >= DEPTH-1). This leaves one slot for the beat already in flight from IF.
- Redirect: redirect_req=1 at an edge does all of the following:
  - Clears the queue (count=0, pointers reset).
  - Drops that cycle's incoming beat.
  - Ignores out_ready.
  - Sets is_flush=1 and branch_target=redirect_pc.
  - Loads drop_cnt=DROP_CYCLES.
  - Forces is_stall=0.
- is_flush: exactly one cycle high per redirect_req cycle. Back-to-back redirects give back-to-back pulses; the last redirect_pc wins.
- drop_cnt: decrements once per cycle in which is_valid && !stall_d1 && drop_cnt!=0; it saturates at 0.
- Pointers: wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.

Optional Feature:
- Macro: FETCH_RX_PC_CHECK_EN.
- When defined:
  - An expected_pc register is maintained. It is loaded with redirect_pc on redirect and set to pc+4 on each accepted beat; it resets to 0.
  - A beat otherwise acceptable whose pc != expected_pc is discarded, not queued.
  - Each discard increments pc_err_cnt, which saturates at 255.
  - The first beat after reset is always accepted and seeds expected_pc.
- When undefined: no check is performed, pc_err_cnt is tied to 0, and no expected_pc logic is synthesised.

Decomposition:
- Shared package fetch_rx_pkg:
  - typedef fetch_beat_t {logic [31:0] pc; logic [31:0] instr;}.
  - Constants RESET_PC=32'h0 and PC_STEP=32'd4.
- One natural sub-module: fetch_fifo_s, a parameterised FWFT FIFO of fetch_beat_t with push, pop, clear, count and a full assertion.
- The top level adds the stall, drop and redirect control.

Test Plan:
- Reset held low 3 cycles with is_valid=1 -> all outputs 0, no push. Release with beats pc=0x4,0x8,0xC and out_ready=1 -> out_pc 0x4,0x8,0xC, each one cycle after its accept.
- out_ready=0 with a continuous stream, DEPTH=4 -> is_stall rises once count reaches 3. The re-presented beat is not pushed twice. The queue holds exactly 4 entries with no overflow.
- Full queue, then out_ready=1 for 2 cycles -> is_stall falls and the stream resumes with no lost or duplicated PC.
- redirect_req=1 with redirect_pc=0x100 while the queue holds 3 -> next cycle: out_valid=0, is_flush=1 for exactly 1 cycle, branch_target=0x100. The next 2 valid beats are dropped; the beat with pc=0x100 is delivered.
- redirect_req coincident with out_ready=1 and an incoming beat -> no pop, beat dropped, queue empty.
- FETCH_RX_PC_CHECK_EN defined: stream 0x4, 0x8, 0x20, 0xC -> 0x20 discarded, pc_err_cnt=1, decode sees 0x4, 0x8, 0xC.
